// File: rtl/issue_ctrl_pkg.sv
// Shared codes, defaults and types for the instruction issue controller.
package issue_ctrl_pkg;

  // Decoder unit classes reported for the head instruction.
  localparam logic [1:0] UNIT_RS  = 2'd0;
  localparam logic [1:0] UNIT_LSB = 2'd1;
  localparam logic [1:0] UNIT_ILL = 2'd3;

  // Encoding of the halt instruction (li a0, 255).
  localparam logic [31:0] HALT_INST = 32'h0ff00513;

  // Default instruction buffer geometry.
  localparam int IQ_DEPTH     = 8;
  localparam int IQ_DEPTH_BIT = 3;

  // Issue sequencing states.
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_WAIT = 2'd1,
    ST_HALTED    = 2'd2
  } issue_state_t;

  // One buffered instruction.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } iq_entry_t;

  // Only RS and LSB classes allocate anything; everything else is dropped.
  function automatic logic unit_legal(input logic [1:0] unit);
    return (unit == UNIT_RS) || (unit == UNIT_LSB);
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Circular instruction buffer with push, pop, flush and combinational head.
module issue_fifo
  import issue_ctrl_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int DEPTH_BIT = IQ_DEPTH_BIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [31:0]        wr_inst,
  input  logic [31:0]        wr_pc,
  input  logic               wr_pred,
  output logic [31:0]        head_inst,
  output logic [31:0]        head_pc,
  output logic               head_pred,
  output logic [DEPTH_BIT:0] count
);

  iq_entry_t            mem [DEPTH];
  logic [DEPTH_BIT-1:0] head;
  logic [DEPTH_BIT-1:0] tail;

  // Pointer and occupancy bookkeeping; flush empties the buffer outright.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset since count guards validity.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[tail] <= '{inst: wr_inst, pc: wr_pc, pred: wr_pred};
    end
  end

  assign head_inst = mem[head].inst;
  assign head_pc   = mem[head].pc;
  assign head_pred = mem[head].pred;

endmodule

// File: rtl/issue_ctrl.sv
// Issue sequencer: buffers fetched instructions, pops the head when the
// target structures can take it, tracks halt and counts stall cycles.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int DEPTH_BIT = IQ_DEPTH_BIT,
  parameter int CNT_W     = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc,
  input  logic             if_pred,
  output logic             if_ready,
  output logic             dec_valid,
  output logic [31:0]      dec_inst,
  output logic [31:0]      dec_pc,
  output logic             dec_guess,
  input  logic [1:0]       dec_unit,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic             lsb_full,
  output logic             issue_fire,
  input  logic             flush_in,
  input  logic             halt_commit,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [DEPTH_BIT:0] FULL_CNT = (DEPTH_BIT+1)'(DEPTH);

  issue_state_t         state;
  logic [DEPTH_BIT:0]   count;
  logic [31:0]          head_inst;
  logic [31:0]          head_pc;
  logic                 head_pred;
  logic                 push;
  logic                 pop;
  logic                 accept;
  logic                 legal;
  logic                 flush_eff;

  // While rdy_in is low the ROB holds its flush, so it is ignored here.
  assign flush_eff = rdy_in & flush_in;
  assign if_ready  = rdy_in & ~flush_in & (count < FULL_CNT) & (state == ST_RUN);
  assign push      = if_valid & if_ready;
  assign dec_valid = (count != '0) & (state == ST_RUN) & ~flush_in;

  // Head fields read as zero whenever nothing is presented.
  assign dec_inst  = dec_valid ? head_inst : 32'h0;
  assign dec_pc    = dec_valid ? head_pc   : 32'h0;
  assign dec_guess = dec_valid ? head_pred : 1'b0;

  // Decide whether the head's target structures can take it this cycle.
  always_comb begin
    accept = 1'b0;
    legal  = unit_legal(dec_unit);
    case (dec_unit)
      UNIT_RS:  accept = ~rob_full & ~rs_full;
      UNIT_LSB: accept = ~rob_full & ~lsb_full;
      UNIT_ILL: accept = 1'b0;
      default:  accept = 1'b0;
    endcase
  end

  // Illegal heads are popped and discarded without allocating anything.
  assign pop        = dec_valid & rdy_in & (accept | ~legal);
  assign issue_fire = pop & legal;

  issue_fifo #(
    .DEPTH     (DEPTH),
    .DEPTH_BIT (DEPTH_BIT)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (push),
    .pop       (pop),
    .flush     (flush_eff),
    .wr_inst   (if_inst),
    .wr_pc     (if_pc),
    .wr_pred   (if_pred),
    .head_inst (head_inst),
    .head_pc   (head_pc),
    .head_pred (head_pred),
    .count     (count)
  );

  // Halt tracking: a halt issue is speculative until the ROB commits it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= ST_RUN;
      halted <= 1'b0;
    end else if (rdy_in) begin
      case (state)
        ST_RUN: begin
          if (!flush_in && issue_fire && (dec_inst == HALT_INST)) begin
            state <= ST_HALT_WAIT;
          end
        end
        ST_HALT_WAIT: begin
          if (flush_in) begin
            state <= ST_RUN;
          end else if (halt_commit) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          state  <= ST_HALTED;
          halted <= 1'b1;
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles where a presented head could not issue.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cnt <= '0;
    end else if (rdy_in && dec_valid && !pop && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
